// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB round-robin master arbiter family:
// FSM state encodings and the packed-bus slice helper.
package apb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SETUP  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;

  // Low bit of requester idx's slice in a packed per-requester bus.
  function automatic int unsigned slice_lo(input int unsigned idx,
                                           input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first unmasked request at or above
// the pointer, wrapping around. Reusable by other arbiters in the family.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic          o_valid,
  output logic [IW-1:0] o_winner
);

  logic [N-1:0]  w_elig;
  logic [IW-1:0] w_idx;

  assign w_elig = i_req & ~i_mask;

  // Scan from the farthest offset down so the nearest hit is written last.
  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = IW'((int'(i_ptr) + i) % N);
      if (w_elig[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB3 master port between NUM_REQ requesters,
// with PCLKEN-qualified SETUP/ACCESS sequencing and a PREADY watchdog.
module apb_rr_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16,
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_REQ-1:0]             REQ,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   REQ_ADDR,
  input  logic [NUM_REQ-1:0]             REQ_WRITE,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   REQ_WDATA,
  output logic [NUM_REQ-1:0]             DONE,
  output logic [DATAWIDTH-1:0]           RDATA,
  output logic                           ERR,
  output logic [IW-1:0]                  GNT_ID,
  output logic                           BUSY,
  input  logic                           PCLKEN,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDRWIDTH-1:0]           PADDR,
  output logic [DATAWIDTH-1:0]           PWDATA,
  input  logic [DATAWIDTH-1:0]           PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR
);

  localparam int              WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]           r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_gnt;
  logic [WDW-1:0]       r_wdog;
  logic [NUM_REQ-1:0]   r_done;
  logic [DATAWIDTH-1:0] r_rdata;
  logic                 r_err;
  logic                 r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [ADDRWIDTH-1:0] r_paddr;
  logic [DATAWIDTH-1:0] r_pwdata;

  logic                 w_valid;
  logic [IW-1:0]        w_win;

  // The requester completing this cycle is masked so a lingering REQ is not re-granted.
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_req    (REQ),
    .i_mask   (r_done),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_winner (w_win)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_wdog    <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_done <= '0;
      if (PCLKEN) begin
        case (r_state)
          ST_IDLE: begin
            if (w_valid) begin
              r_state   <= ST_SETUP;
              r_gnt     <= w_win;
              r_ptr     <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
              r_psel    <= 1'b1;
              r_penable <= 1'b0;
              r_pwrite  <= REQ_WRITE[w_win];
              r_paddr   <= REQ_ADDR[slice_lo(32'(w_win), ADDRWIDTH) +: ADDRWIDTH];
              r_pwdata  <= REQ_WDATA[slice_lo(32'(w_win), DATAWIDTH) +: DATAWIDTH];
            end
          end
          ST_SETUP: begin
            r_state   <= ST_ACCESS;
            r_penable <= 1'b1;
            r_wdog    <= '0;
          end
          ST_ACCESS: begin
            if (PREADY) begin
              r_state        <= ST_IDLE;
              r_done[r_gnt]  <= 1'b1;
              r_rdata        <= r_pwrite ? '0 : PRDATA;
              r_err          <= PSLVERR;
              r_psel         <= 1'b0;
              r_penable      <= 1'b0;
            end else if (TIMEOUT != 0) begin
              if (r_wdog == WD_LAST) begin
                r_state        <= ST_IDLE;
                r_done[r_gnt]  <= 1'b1;
                r_rdata        <= '0;
                r_err          <= 1'b1;
                r_psel         <= 1'b0;
                r_penable      <= 1'b0;
                r_pwrite       <= 1'b0;
                r_paddr        <= '0;
                r_pwdata       <= '0;
                r_wdog         <= '0;
              end else begin
                r_wdog <= r_wdog + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign DONE    = r_done;
  assign RDATA   = r_rdata;
  assign ERR     = r_err;
  assign GNT_ID  = r_gnt;
  assign BUSY    = (r_state != ST_IDLE);
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;

endmodule
